// File: rtl/var_clk_gen.sv
// Variable clock generator: 50%-duty divided clock plus first-high-cycle enable,
// with a req/ack handshake that switches divisor only at a low-phase boundary.
module var_clk_gen #(
   parameter int                      NUM_CH    = 4,
   parameter int                      SEL_W     = 2,
   parameter int                      DIV_W     = 8,
   parameter logic [NUM_CH*DIV_W-1:0] DIV_TABLE = 32'h01020300,
   parameter int                      RESET_SEL = 0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_req,
   input  logic [SEL_W-1:0] i_sel,
   output logic             o_var_clk,
   output logic             o_clk_en,
   output logic             o_busy,
   output logic             o_ack,
   output logic             o_err,
   output logic [SEL_W-1:0] o_cur_sel
);

   typedef enum logic [1:0] {ST_STOP, ST_HIGH, ST_LOW} state_t;

   localparam logic [DIV_W-1:0] RESET_DIV = DIV_TABLE[RESET_SEL*DIV_W +: DIV_W];
   localparam state_t           RESET_ST  = (RESET_DIV == '0) ? ST_STOP : ST_LOW;
   localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

   function automatic logic [DIV_W-1:0] div_of(input logic [SEL_W-1:0] sel);
      return DIV_TABLE[int'(sel)*DIV_W +: DIV_W];
   endfunction

   state_t           state;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_q;
   logic             pend;
   logic [SEL_W-1:0] pend_sel;

   logic             sel_ok;
   logic             req_ok;
   logic             req_bad;
   logic             apply;
   logic [DIV_W-1:0] new_div;

   assign sel_ok  = int'(i_sel) < NUM_CH;
   assign req_ok  = i_req & sel_ok;
   assign req_bad = i_req & ~sel_ok;
   // Switching only when a low phase has fully elapsed (or from STOP) keeps every phase whole.
   assign apply   = pend & ((state == ST_STOP) | ((state == ST_LOW) & (cnt == '0)));
   assign new_div = div_of(pend_sel);
   assign o_busy  = pend;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= RESET_ST;
         cnt       <= '0;
         div_q     <= RESET_DIV;
         pend      <= 1'b0;
         pend_sel  <= SEL_W'(RESET_SEL);
         o_var_clk <= 1'b0;
         o_clk_en  <= 1'b0;
         o_ack     <= 1'b0;
         o_err     <= 1'b0;
         o_cur_sel <= SEL_W'(RESET_SEL);
      end else begin
         o_ack    <= 1'b0;
         o_clk_en <= 1'b0;
         o_err    <= req_bad;

         if (apply) begin
            div_q     <= new_div;
            o_cur_sel <= pend_sel;
            o_ack     <= 1'b1;
            if (new_div == '0) begin
               state     <= ST_STOP;
               cnt       <= '0;
               o_var_clk <= 1'b0;
            end else begin
               state     <= ST_HIGH;
               cnt       <= new_div - ONE;
               o_var_clk <= 1'b1;
               o_clk_en  <= 1'b1;
            end
         end else begin
            case (state)
               ST_STOP: begin
                  o_var_clk <= 1'b0;
               end
               ST_HIGH: begin
                  if (cnt == '0) begin
                     state     <= ST_LOW;
                     cnt       <= div_q - ONE;
                     o_var_clk <= 1'b0;
                  end else begin
                     cnt <= cnt - ONE;
                  end
               end
               ST_LOW: begin
                  if (cnt == '0) begin
                     state     <= ST_HIGH;
                     cnt       <= div_q - ONE;
                     o_var_clk <= 1'b1;
                     o_clk_en  <= 1'b1;
                  end else begin
                     cnt <= cnt - ONE;
                  end
               end
               default: begin
                  state     <= ST_STOP;
                  cnt       <= '0;
                  o_var_clk <= 1'b0;
               end
            endcase
         end

         // A request on an apply edge survives as the next pending one.
         if (req_ok) begin
            pend     <= 1'b1;
            pend_sel <= i_sel;
         end else if (apply) begin
            pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_var_clk_gen.sv
// Directed bench for var_clk_gen: default instance, a 3-channel instance for
// rejected selects, and an instance resetting into a running divisor with a 255 setting.
module tb_var_clk_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req, req3, reqr;
   logic [1:0] sel, sel3, selr;

   logic       var_clk, clk_en, busy, ack, err;
   logic [1:0] cur_sel;
   logic       var3, cen3, busy3, ack3, err3;
   logic [1:0] cur3;
   logic       varr, cenr, busyr, ackr, errr;
   logic [1:0] curr;

   int n_vec = 0;
   int n_err = 0;
   int n, hi, lo;
   logic [10:0] vpat;
   logic [5:0]  vpat2;

   always #5 clk = ~clk;

   var_clk_gen dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_sel(sel),
      .o_var_clk(var_clk), .o_clk_en(clk_en), .o_busy(busy), .o_ack(ack),
      .o_err(err), .o_cur_sel(cur_sel)
   );

   var_clk_gen #(.NUM_CH(3), .SEL_W(2), .DIV_W(8), .DIV_TABLE(24'h020300), .RESET_SEL(0)) dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req3), .i_sel(sel3),
      .o_var_clk(var3), .o_clk_en(cen3), .o_busy(busy3), .o_ack(ack3),
      .o_err(err3), .o_cur_sel(cur3)
   );

   var_clk_gen #(.NUM_CH(4), .SEL_W(2), .DIV_W(8), .DIV_TABLE(32'h01FF0300), .RESET_SEL(3)) dutr (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(reqr), .i_sel(selr),
      .o_var_clk(varr), .o_clk_en(cenr), .o_busy(busyr), .o_ack(ackr),
      .o_err(errr), .o_cur_sel(curr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (ack !== 1'b1 && cyc < 50);
   endtask

   initial begin
      rst_n = 1'b1;
      req = 1'b0;  sel = 2'd0;
      req3 = 1'b0; sel3 = 2'd0;
      reqr = 1'b0; selr = 2'd0;
      #2 rst_n = 1'b0;
      tick();
      tick();

      // reset state
      check("rst_var", var_clk, 1'b0);
      check("rst_en", clk_en, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_ack", ack, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_cur", cur_sel, 2'd0);
      check("rst_r_cur", curr, 2'd3);
      check("rst_r_var", varr, 1'b0);
      check("rst_r_busy", busyr, 1'b0);
      check("rst_r_err", errr, 1'b0);
      check("rst_3_busy", busy3, 1'b0);

      // idle in STOP; RESET_SEL=3 instance toggles from the first edge
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("idle_var", var_clk, 1'b0);
         check("idle_busy", busy, 1'b0);
         check("idle_cur", cur_sel, 2'd0);
         check("r_toggle", varr, (i % 2 == 0) ? 1'b1 : 1'b0);
         check("r_toggle_en", cenr, (i % 2 == 0) ? 1'b1 : 1'b0);
      end

      // from STOP, request D=3
      req = 1'b1; sel = 2'd1;
      tick();
      req = 1'b0;
      check("s1_busy", busy, 1'b1);
      check("s1_ack_early", ack, 1'b0);
      check("s1_var_early", var_clk, 1'b0);
      tick();
      check("s1_ack", ack, 1'b1);
      check("s1_en", clk_en, 1'b1);
      check("s1_var", var_clk, 1'b1);
      check("s1_busy_clr", busy, 1'b0);
      check("s1_cur", cur_sel, 2'd1);
      vpat = 11'b11000111000;
      for (int i = 0; i < 11; i++) begin
         tick();
         check("s1_wave", var_clk, vpat[10-i]);
         check("s1_wave_en", clk_en, (i == 5) ? 1'b1 : 1'b0);
      end

      // request D=1 from the last low cycle; boundary edge itself does not apply
      req = 1'b1; sel = 2'd3;
      tick();
      req = 1'b0;
      check("s3_busy", busy, 1'b1);
      check("s3_var", var_clk, 1'b1);
      wait_ack(n);
      check("s3_ack_lat", n, 6);
      check("s3_var_on_ack", var_clk, 1'b1);
      check("s3_en_on_ack", clk_en, 1'b1);
      check("s3_cur", cur_sel, 2'd3);
      check("s3_busy_clr", busy, 1'b0);

      // mid-high request back to D=3: 1-cycle high and low complete first
      req = 1'b1; sel = 2'd1;
      tick();
      req = 1'b0;
      check("sw_low", var_clk, 1'b0);
      check("sw_busy", busy, 1'b1);
      check("sw_no_ack", ack, 1'b0);
      tick();
      check("sw_ack", ack, 1'b1);
      check("sw_var", var_clk, 1'b1);
      check("sw_en", clk_en, 1'b1);
      check("sw_cur", cur_sel, 2'd1);
      vpat2 = 6'b110001;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("sw_wave", var_clk, vpat2[5-i]);
      end

      // two requests while busy: only the last (off) is acked
      req = 1'b1; sel = 2'd2;
      tick();
      check("dbl_busy1", busy, 1'b1);
      check("dbl_var1", var_clk, 1'b1);
      sel = 2'd0;
      tick();
      req = 1'b0;
      check("dbl_busy2", busy, 1'b1);
      check("dbl_no_ack", ack, 1'b0);
      wait_ack(n);
      check("dbl_ack_lat", n, 4);
      check("dbl_cur", cur_sel, 2'd0);
      check("dbl_var", var_clk, 1'b0);
      check("dbl_busy_clr", busy, 1'b0);
      check("dbl_en", clk_en, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("dbl_single_ack", ack, 1'b0);
         check("dbl_stopped", var_clk, 1'b0);
      end

      // invalid select on a 3-channel instance
      req3 = 1'b1; sel3 = 2'd2;
      tick();
      req3 = 1'b0;
      check("e_busy", busy3, 1'b1);
      tick();
      check("e_ack", ack3, 1'b1);
      check("e_var", var3, 1'b1);
      check("e_cur", cur3, 2'd2);
      req3 = 1'b1; sel3 = 2'd3;
      tick();
      req3 = 1'b0;
      check("e_err", err3, 1'b1);
      check("e_no_busy", busy3, 1'b0);
      check("e_no_ack", ack3, 1'b0);
      check("e_var_hold", var3, 1'b1);
      tick();
      check("e_err_pulse", err3, 1'b0);
      check("e_var_low1", var3, 1'b0);
      tick();
      check("e_var_low2", var3, 1'b0);
      tick();
      check("e_var_high", var3, 1'b1);
      check("e_en", cen3, 1'b1);
      check("e_cur_kept", cur3, 2'd2);

      // maximum divisor 255: each phase exactly 255 cycles
      reqr = 1'b1; selr = 2'd2;
      tick();
      reqr = 1'b0;
      n = 0;
      while (ackr !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      check("max_ack", ackr, 1'b1);
      check("max_cur", curr, 2'd2);
      hi = 1;
      while (varr === 1'b1 && hi < 600) begin
         tick();
         if (varr === 1'b1) hi++;
      end
      lo = 1;
      while (varr === 1'b0 && lo < 600) begin
         tick();
         if (varr === 1'b0) lo++;
      end
      check("max_high_len", hi, 255);
      check("max_low_len", lo, 255);
      check("max_en", cenr, 1'b1);

      // same-edge request during apply, then reset mid-high while busy
      req = 1'b1; sel = 2'd2;
      tick();
      check("r_busy", busy, 1'b1);
      sel = 2'd1;
      tick();
      req = 1'b0;
      check("r_ack", ack, 1'b1);
      check("r_cur", cur_sel, 2'd2);
      check("r_var", var_clk, 1'b1);
      check("r_busy_kept", busy, 1'b1);
      tick();
      check("r_var_hi2", var_clk, 1'b1);
      check("r_busy2", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("ra_var", var_clk, 1'b0);
      check("ra_busy", busy, 1'b0);
      check("ra_cur", cur_sel, 2'd0);
      check("ra_en", clk_en, 1'b0);
      check("ra_ack", ack, 1'b0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_var", var_clk, 1'b0);
         check("post_busy", busy, 1'b0);
         check("post_ack", ack, 1'b0);
         check("post_cur", cur_sel, 2'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/var_clk_gen.md
# var_clk_gen

Parametrised, single-clock-domain variable clock generator, successor to the fixed PLL-plus-mux generator used in the power demo. It derives a 50 %-duty divided clock `o_var_clk` and a matching one-cycle enable `o_clk_en` from `i_clk`, choosing among `NUM_CH` programmable divisors; divisor 0 is the "off" setting. Frequency changes use a req/ack handshake and take effect only at a low-phase boundary, so no runt pulse is ever produced. It sits between the power-state controller, which issues requests, and the downstream load logic, which consumes the clock or enable.

## Interface
- `NUM_CH`, 4: number of selectable settings (≥2).
- `SEL_W`, 2: select width; must satisfy 2^SEL_W ≥ NUM_CH.
- `DIV_W`, 8: divisor width.
- `DIV_TABLE`, 32'h01020300: packed divisors. Setting i is `DIV_TABLE[i*DIV_W +: DIV_W]`. Default: ch0 = 0 (off), ch1 = 3, ch2 = 2, ch3 = 1.
- `RESET_SEL`, 0: setting active after reset.
- `i_clk`  in  1  sole clock; all logic is on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  request strobe, sampled on each rising edge.
- `i_sel`  in  SEL_W  requested setting; valid when `i_req` = 1.
- `o_var_clk`  out  1  divided clock, registered.
- `o_clk_en`  out  1  one-cycle pulse coincident with each cycle in which `o_var_clk` is high for the first cycle of its high phase.
- `o_busy`  out  1  a request is pending and not yet applied.
- `o_ack`  out  1  one-cycle pulse: pending request applied.
- `o_err`  out  1  one-cycle pulse: request rejected because `i_sel` ≥ `NUM_CH`.
- `o_cur_sel`  out  SEL_W  setting currently in effect.

## Operation
- Registers: state ∈ {STOP, HIGH, LOW}; counter `cnt` [DIV_W-1:0]; current divisor D; pending flag; pending select.
- Output waveform for D > 0: `o_var_clk` is high for D cycles, then low for D cycles, giving a period of 2·D.
- STOP (D = 0): `o_var_clk` = 0 and `o_clk_en` = 0.
- HIGH:
  - `o_var_clk` = 1 and `cnt` decrements.
  - When `cnt` = 0: go to LOW with `cnt` = D−1.
- LOW:
  - `o_var_clk` = 0 and `cnt` decrements.
  - When `cnt` = 0 with no pending request: go to HIGH with `cnt` = D−1 and assert `o_clk_en`.
  - When `cnt` = 0 with a pending request: apply it.
- Apply a request:
  - Load D from the table and set `o_cur_sel`.
  - Clear pending and `o_busy`, and pulse `o_ack`.
  - If the new D = 0: go to STOP.
  - Otherwise: go to HIGH with `cnt` = new D−1 and assert `o_clk_en`.
- Request accepted (`i_req` = 1 and `i_sel` < `NUM_CH`): set pending and record `i_sel`; `o_busy` = 1 from the next cycle.
- Request while already busy: overwrites the pending select. Only one `o_ack` is issued, for the last value.
- Request with `i_sel` ≥ `NUM_CH`: ignored; pulse `o_err`; pending state unchanged.
- Request for the setting already in effect: completes the full handshake at the next boundary; the waveform is unchanged.
- Request accepted in STOP: applied on the next edge.
- Request on the same edge as a boundary apply: the apply uses the previously pending select. The new request becomes pending afterwards; no request is lost.
- Reset (asserted at any time, including mid-phase or while busy):
  - Outputs: `o_var_clk` = 0, `o_clk_en` = 0, `o_busy` = 0, `o_ack` = 0, `o_err` = 0, `o_cur_sel` = `RESET_SEL`.
  - Pending request is discarded.
  - State becomes STOP if the `RESET_SEL` divisor is 0; otherwise LOW with `cnt` = 0, so the first high phase starts on the first edge after release.
- Divisor 1 yields a toggle every cycle (period 2) with `o_clk_en` every other cycle. The maximum divisor, 2^DIV_W − 1, must be supported without counter overflow.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- `i_req` sampled at edge k: `o_busy` or `o_err` visible after edge k.
- Apply latency from STOP: edge k+1.
- Apply latency from HIGH/LOW: the edge that ends the current low phase. Worst case is 2·D_old cycles after k.
- Visibility at the apply edge: `o_ack`, the new `o_cur_sel`, and `o_busy` = 0 are visible after the same apply edge, together with the first new `o_var_clk` level.
- Glitch-free guarantee: every high phase and every low phase is exactly D cycles of the divisor in effect when that phase started.

## Test plan
- Reset with defaults, release, hold `i_req` = 0 → `o_var_clk` = 0, `o_busy` = 0 and `o_cur_sel` = 0, indefinitely.
- From STOP, request sel 1 (D = 3) at edge k → `o_busy` after k; `o_ack` and `o_clk_en` after k+1; then `o_var_clk` pattern 111000, repeating.
- Running sel 3 (D = 1), request sel 1 mid-high phase → the current high and low phases complete at 1 cycle each; switch occurs at the low-phase end; no phase shorter than its divisor.
- Two requests while busy (sel 2, then sel 0) → single `o_ack`; `o_cur_sel` = 0; `o_var_clk` stays 0 after that boundary.
- Request `i_sel` = 3 with `NUM_CH` = 3 → one-cycle `o_err`; no `o_busy`; waveform unchanged.
- Assert `i_rst_n` low mid-high phase while busy → immediate `o_var_clk` = 0 and `o_busy` = 0; after release, resumes per `RESET_SEL`.
